// File: rtl/fpau_arb.sv
// fpau_arb: two-port round-robin arbiter in front of a single FPU.
// One operation in flight at a time; the response is routed back to the issuing port.
`ifndef FPU_OP_WIDTH
`define FPU_OP_WIDTH 5
`endif

module fpau_arb #(
  parameter int OP_W    = `FPU_OP_WIDTH,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [OP_W-1:0] req_op0,
  input  logic [OP_W-1:0] req_op1,
  input  logic [31:0]     req_x1_0,
  input  logic [31:0]     req_x1_1,
  input  logic [31:0]     req_x2_0,
  input  logic [31:0]     req_x2_1,
  output logic [1:0]      resp_valid,
  output logic [31:0]     resp_y32,
  output logic            resp_y1,
  output logic            resp_err,
  output logic [31:0]     fpu_x1,
  output logic [31:0]     fpu_x2,
  output logic [OP_W-1:0] fpu_op,
  output logic            fpu_ready,
  input  logic [31:0]     fpu_y32,
  input  logic            fpu_y1,
  input  logic            fpu_valid
);
  localparam int         NUM_PORTS = 2;
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [31:0]     x1;
    logic [31:0]     x2;
  } req_t;

  state_t               state, state_nxt;
  req_t [NUM_PORTS-1:0] reqs;
  req_t                 held;
  logic                 owner, ptr, gnt_id, accept, to_hit;
  logic [7:0]           wait_cnt;

  assign reqs[0] = {req_op0, req_x1_0, req_x2_0};
  assign reqs[1] = {req_op1, req_x1_1, req_x2_1};

  // pointer only matters when both ports request; a lone requester always wins
  assign gnt_id = (&req_valid) ? ptr : req_valid[1];
  assign accept = rstn && (state == IDLE) && (|req_valid);
  assign to_hit = (wait_cnt == TO_LAST);

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign req_ready[i]  = accept && (gnt_id == 1'(i));
    assign resp_valid[i] = (state == RESP) && (owner == 1'(i));
  end

  assign fpu_ready = (state == ISSUE);
  assign fpu_op    = (state == IDLE) ? '0 : held.op;
  assign fpu_x1    = (state == IDLE) ? '0 : held.x1;
  assign fpu_x2    = (state == IDLE) ? '0 : held.x2;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = fpu_valid ? RESP : WAIT;
      WAIT:    if (fpu_valid || to_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      owner    <= 1'b0;
      held     <= '0;
      wait_cnt <= '0;
      resp_y32 <= '0;
      resp_y1  <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner <= gnt_id;
        ptr   <= ~gnt_id;
        held  <= reqs[gnt_id];
      end
      if (state == ISSUE)
        wait_cnt <= '0;
      else if (state == WAIT && !fpu_valid)
        wait_cnt <= wait_cnt + 8'd1;
      // a real result wins over the timeout when both land in the last WAIT cycle
      if ((state == ISSUE || state == WAIT) && fpu_valid) begin
        resp_y32 <= fpu_y32;
        resp_y1  <= fpu_y1;
        resp_err <= 1'b0;
      end else if (state == WAIT && to_hit) begin
        resp_y32 <= '0;
        resp_y1  <= 1'b0;
        resp_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fpau_arb.sv
// Bench for fpau_arb: directed vector table, hand sequences for reset/alternation,
// then randomized traffic against a transaction-level timing model.
module tb_fpau_arb;
  localparam int OP_W = 5;
  localparam int TO   = 4;
  localparam logic [OP_W-1:0] FADD = 5'd0;
  localparam logic [OP_W-1:0] FCLT = 5'd12;

  logic            clk = 1'b0, rstn = 1'b0;
  logic [1:0]      req_valid = '0, req_ready, resp_valid;
  logic [OP_W-1:0] req_op0 = '0, req_op1 = '0, fpu_op;
  logic [31:0]     req_x1_0 = '0, req_x1_1 = '0, req_x2_0 = '0, req_x2_1 = '0;
  logic [31:0]     resp_y32, fpu_x1, fpu_x2, fpu_y32 = '0;
  logic            resp_y1, resp_err, fpu_ready, fpu_y1 = 1'b0, fpu_valid = 1'b0;

  fpau_arb #(.OP_W(OP_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1), .req_x1_0(req_x1_0), .req_x1_1(req_x1_1),
    .req_x2_0(req_x2_0), .req_x2_1(req_x2_1), .resp_valid(resp_valid),
    .resp_y32(resp_y32), .resp_y1(resp_y1), .resp_err(resp_err),
    .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_op(fpu_op), .fpu_ready(fpu_ready),
    .fpu_y32(fpu_y32), .fpu_y1(fpu_y1), .fpu_valid(fpu_valid)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  typedef struct {
    logic            port;
    logic [OP_W-1:0] op;
    logic [31:0]     x1, x2;
    int              d;      // cycles after fpu_ready that the FPU answers
    logic [31:0]     fy32;
    logic            fy1;
    logic [1:0]      e_rv;
    logic [31:0]     e_y32;
    logic            e_y1, e_err;
    int              e_lat;  // accept-to-resp_valid cycles
  } vec_t;
  vec_t vt[6];

  // random-phase model state
  int              idle_at, acc_cyc, resp_cyc, fv_cyc, d;
  logic            mptr, own, grant, in_idle, e_frdy;
  logic [1:0]      pend, e_rdy, e_rv;
  logic [OP_W-1:0] h_op;
  logic [31:0]     h_x1, h_x2, r_y32, pl_y32, fv_y32;
  logic            r_y1, r_err, pl_y1, pl_err, fv_y1;
  logic [OP_W-1:0] p_op[2];
  logic [31:0]     p_x1[2], p_x2[2];
  logic [127:0]    e_vec;
  logic [69:0]     e_fpu;
  int              nacc, exp_port;
  logic            q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic [1:0] rdy, input logic [1:0] rv,
      input logic frdy, input logic [OP_W-1:0] op, input logic [31:0] x1,
      input logic [31:0] x2, input logic [31:0] y32, input logic y1, input logic err);
    return 128'({rdy, rv, frdy, op, x1, x2, y32, y1, err});
  endfunction

  function automatic logic [127:0] snap();
    return pack(req_ready, resp_valid, fpu_ready, fpu_op, fpu_x1, fpu_x2, resp_y32, resp_y1, resp_err);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_port(input logic p, input logic [OP_W-1:0] op,
                            input logic [31:0] x1, input logic [31:0] x2);
    if (p) begin req_op1 = op; req_x1_1 = x1; req_x2_1 = x2; end
    else   begin req_op0 = op; req_x1_0 = x1; req_x2_0 = x2; end
  endtask

  task automatic scramble(input logic p);
    drive_port(p, OP_W'($urandom), $urandom, $urandom);
  endtask

  task automatic do_reset();
    rstn = 1'b0; req_valid = '0; fpu_valid = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    vt[0] = '{1'b0, FADD,  32'h3F800000, 32'h40000000, 2, 32'h40400000, 1'b0, 2'b01, 32'h40400000, 1'b0, 1'b0, 4};
    vt[1] = '{1'b1, FCLT,  32'h3F800000, 32'h40000000, 0, 32'h00000001, 1'b1, 2'b10, 32'h00000001, 1'b1, 1'b0, 2};
    vt[2] = '{1'b0, 5'd3,  32'h01234567, 32'h89ABCDEF, 4, 32'hDEADBEEF, 1'b0, 2'b01, 32'hDEADBEEF, 1'b0, 1'b0, 6};
    vt[3] = '{1'b1, 5'd2,  32'h11112222, 32'h33334444, 5, 32'h12345678, 1'b1, 2'b10, 32'h00000000, 1'b0, 1'b1, 6};
    vt[4] = '{1'b0, 5'd1,  32'h55556666, 32'h77778888, 6, 32'hCAFEF00D, 1'b1, 2'b01, 32'h00000000, 1'b0, 1'b1, 6};
    vt[5] = '{1'b1, 5'd4,  32'h9999AAAA, 32'hBBBBCCCC, 1, 32'h0BADF00D, 1'b0, 2'b10, 32'h0BADF00D, 1'b0, 1'b0, 3};

    // reset: outputs low even with requests and fpu_valid asserted
    rstn = 1'b0; req_valid = 2'b11; fpu_valid = 1'b1; scramble(0); scramble(1);
    for (int k = 0; k < 2; k++) begin
      tick();
      @(negedge clk);
      chk("rst_outputs", snap(), '0);
    end
    tick();
    rstn = 1'b1; req_valid = '0;
    @(negedge clk);
    chk("post_rst_idle", snap(), '0);
    tick();
    fpu_valid = 1'b0;

    // directed single-transaction vectors
    for (int i = 0; i < 6; i++) begin
      req_valid = vt[i].port ? 2'b10 : 2'b01;
      drive_port(vt[i].port, vt[i].op, vt[i].x1, vt[i].x2);
      scramble(~vt[i].port);
      @(negedge clk);
      chk("tv_ready", req_ready, vt[i].port ? 2'b10 : 2'b01);
      tick();
      req_valid = '0;
      for (int k = 1; k <= 10; k++) begin
        scramble(0); scramble(1);
        fpu_valid = (k == 1 + vt[i].d);
        fpu_y32   = fpu_valid ? vt[i].fy32 : $urandom;
        fpu_y1    = fpu_valid ? vt[i].fy1  : 1'($urandom);
        @(negedge clk);
        e_fpu = (k <= vt[i].e_lat) ? {(k == 1), vt[i].op, vt[i].x1, vt[i].x2} : '0;
        chk("tv_fpu_side", {fpu_ready, fpu_op, fpu_x1, fpu_x2}, e_fpu);
        chk("tv_resp_valid", resp_valid, (k == vt[i].e_lat) ? vt[i].e_rv : 2'b00);
        if (k >= vt[i].e_lat)
          chk("tv_payload", {resp_y32, resp_y1, resp_err}, {vt[i].e_y32, vt[i].e_y1, vt[i].e_err});
        tick();
      end
      fpu_valid = 1'b0;
    end

    // both ports request continuously: grants alternate, responses go to the issuer
    do_reset();
    req_valid = 2'b11; fpu_valid = 1'b1;
    drive_port(0, 5'd1, 32'hA0A0A0A0, 32'hA1A1A1A1);
    drive_port(1, 5'd2, 32'hB0B0B0B0, 32'hB1B1B1B1);
    nacc = 0; exp_port = 0; q.delete();
    for (int k = 0; k < 18; k++) begin
      fpu_y32 = 32'(k);
      @(negedge clk);
      if (req_ready != 2'b00) begin
        chk("alt_accept", req_ready, exp_port ? 2'b10 : 2'b01);
        q.push_back(exp_port[0]);
        exp_port ^= 1;
        nacc++;
      end
      if (resp_valid != 2'b00) begin
        if (q.size() == 0) chk("alt_resp_spurious", resp_valid, 2'b00);
        else begin
          chk("alt_resp_owner", resp_valid, q.pop_front() ? 2'b10 : 2'b01);
          chk("alt_payload", resp_y32, 32'(k - 1));
        end
      end
      tick();
    end
    chk("alt_count", nacc, 6);
    req_valid = '0; fpu_valid = 1'b0;

    // reset mid-WAIT aborts silently and returns the pointer to port 0
    do_reset();
    req_valid = 2'b11;
    drive_port(0, 5'd3, 32'h11111111, 32'h22222222);
    drive_port(1, 5'd4, 32'h33333333, 32'h44444444);
    @(negedge clk);
    chk("rw_accept", req_ready, 2'b01);
    tick();
    req_valid = 2'b10;
    tick();
    scramble(1);
    @(negedge clk);
    chk("rw_hold_wait1", {resp_valid, fpu_op, fpu_x1, fpu_x2}, {2'b00, 5'd3, 32'h11111111, 32'h22222222});
    tick();
    scramble(1); rstn = 1'b0;
    @(negedge clk);
    chk("rw_hold_wait2", {resp_valid, fpu_op, fpu_x1, fpu_x2}, {2'b00, 5'd3, 32'h11111111, 32'h22222222});
    tick();
    rstn = 1'b1; req_valid = 2'b11;
    @(negedge clk);
    chk("rw_after_rst", snap(), pack(2'b01, 2'b00, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0));
    tick();
    req_valid = '0;
    repeat (8) tick();

    // randomized traffic against the transaction-level model
    do_reset();
    idle_at = 0; mptr = 1'b0; own = 1'b0; acc_cyc = -10; resp_cyc = -10; fv_cyc = -10;
    pl_y32 = '0; pl_y1 = 1'b0; pl_err = 1'b0; pend = '0;
    h_op = '0; h_x1 = '0; h_x2 = '0; r_y32 = '0; r_y1 = 1'b0; r_err = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1'b1; p_op[p] = OP_W'($urandom); p_x1[p] = $urandom; p_x2[p] = $urandom;
        end else if (pend[p] && $urandom_range(0, 15) == 0)
          pend[p] = 1'b0;
        if (pend[p]) drive_port(p[0], p_op[p], p_x1[p], p_x2[p]);
        else         scramble(p[0]);
      end
      req_valid = pend;
      fpu_valid = (c == fv_cyc) || (c >= idle_at && $urandom_range(0, 3) == 0);
      fpu_y32   = (c == fv_cyc) ? fv_y32 : $urandom;
      fpu_y1    = (c == fv_cyc) ? fv_y1  : 1'($urandom);
      @(negedge clk);
      in_idle = (c >= idle_at);
      grant   = (req_valid == 2'b11) ? mptr : req_valid[1];
      e_rdy   = (in_idle && req_valid != 2'b00) ? (grant ? 2'b10 : 2'b01) : 2'b00;
      e_rv    = 2'b00;
      if (!in_idle && c == resp_cyc) begin
        pl_y32 = r_y32; pl_y1 = r_y1; pl_err = r_err;
        e_rv = own ? 2'b10 : 2'b01;
      end
      e_frdy = !in_idle && (c == acc_cyc + 1);
      e_vec = in_idle ? pack(e_rdy, e_rv, 1'b0, '0, '0, '0, pl_y32, pl_y1, pl_err)
                      : pack(e_rdy, e_rv, e_frdy, h_op, h_x1, h_x2, pl_y32, pl_y1, pl_err);
      chk("rnd_cycle", snap(), e_vec);
      if (e_rdy != 2'b00) begin
        own = grant; mptr = ~grant; acc_cyc = c;
        h_op = p_op[grant]; h_x1 = p_x1[grant]; h_x2 = p_x2[grant];
        pend[grant] = 1'b0;
        d = $urandom_range(0, TO + 2);
        fv_cyc = c + 1 + d; fv_y32 = $urandom; fv_y1 = 1'($urandom);
        if (d <= TO) begin
          r_y32 = fv_y32; r_y1 = fv_y1; r_err = 1'b0; resp_cyc = c + 2 + d;
        end else begin
          r_y32 = '0; r_y1 = 1'b0; r_err = 1'b1; resp_cyc = c + 2 + TO;
        end
        idle_at = resp_cyc + 1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
